// File: rtl/riscx_div_pkg.sv
// Shared types and constants for the RISC-V M-extension divide path.
// Operation encoding follows the funct3[1:0] order DIV, DIVU, REM, REMU.
package riscx_div_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FIXUP,
        S_RESP,
        S_DRAIN
    } div_ctrl_state_e;

    localparam logic [XLEN-1:0] DIV_ZERO_QUOT = '1;
    localparam logic [XLEN-1:0] XLEN_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic op_is_signed(div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// EX-side request/response bus of the divide controller; suffixes are from the controller's view.
// Request is valid/ready, response is valid/ready, flush kills the in-flight op.
interface div_issue_ctrl_if;
    import riscx_div_pkg::*;

    logic            req_valid_i;
    logic            req_ready_o;
    div_op_e         op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_data_o;

    modport slave (
        input  req_valid_i, op_i, rs1_i, rs2_i, flush_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );

    modport master (
        output req_valid_i, op_i, rs1_i, rs2_i, flush_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );

endinterface

// File: rtl/div_sign_fix.sv
// Two-lane conditional two's-complement negate: abs() on operands, sign restore on results.
// Purely combinational; abs of the most negative value wraps back to itself.
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         neg_a_i,
    input  logic         neg_b_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    assign a_o = neg_a_i ? -a_i : a_i;
    assign b_o = neg_b_i ? -b_i : b_i;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues DIV/DIVU/REM/REMU to an unsigned iterative core; fast path 1 cycle, normal done+2.
// One op in flight; req_ready only in IDLE, response held until rsp_ready_i or flush.
module div_issue_ctrl
    import riscx_div_pkg::*;
(
    input  logic            clock,
    input  logic            nreset,
    div_issue_ctrl_if.slave ex,
    output logic            div_valid_o,
    output logic [XLEN-1:0] div_a_o,
    output logic [XLEN-1:0] div_b_o,
    input  logic            div_done_i,
    input  logic [XLEN-1:0] div_quot_i,
    input  logic [XLEN-1:0] div_rem_i,
    output logic [31:0]     last_cycles_o
);

    div_ctrl_state_e state_q;
    div_op_e         op_q;
    logic            neg_quot_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] rem_q;
    logic            div_valid_q;
    logic [XLEN-1:0] div_a_q;
    logic [XLEN-1:0] div_b_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [31:0]     cnt_q;
    logic [31:0]     last_q;

    logic            accept;
    logic            sgn_op;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_by_zero;
    logic            sgn_ovf;
    logic            fast_path;
    logic [XLEN-1:0] fast_data;
    logic [XLEN-1:0] fix_quot;
    logic [XLEN-1:0] fix_rem;

    assign ex.req_ready_o = (state_q == S_IDLE) && !ex.flush_i;
    assign accept         = ex.req_valid_i && ex.req_ready_o;

    assign sgn_op = op_is_signed(ex.op_i);
    assign sign_a = sgn_op && ex.rs1_i[XLEN-1];
    assign sign_b = sgn_op && ex.rs2_i[XLEN-1];

    div_sign_fix #(.W(XLEN)) u_opnd_fix (
        .a_i     (ex.rs1_i),
        .b_i     (ex.rs2_i),
        .neg_a_i (sign_a),
        .neg_b_i (sign_b),
        .a_o     (mag_a),
        .b_o     (mag_b)
    );

    div_sign_fix #(.W(XLEN)) u_res_fix (
        .a_i     (quot_q),
        .b_i     (rem_q),
        .neg_a_i (neg_quot_q),
        .neg_b_i (neg_rem_q),
        .a_o     (fix_quot),
        .b_o     (fix_rem)
    );

    // Cases the core must never see: zero divisor and INT_MIN / -1.
    assign div_by_zero = (ex.rs2_i == '0);
    assign sgn_ovf     = sgn_op && (ex.rs1_i == XLEN_INT_MIN) && (ex.rs2_i == '1);
    assign fast_path   = div_by_zero || sgn_ovf;

    always_comb begin
        fast_data = '0;
        if (div_by_zero) begin
            fast_data = op_is_rem(ex.op_i) ? ex.rs1_i : DIV_ZERO_QUOT;
        end else if (!op_is_rem(ex.op_i)) begin
            fast_data = XLEN_INT_MIN;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_DIV;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            div_valid_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
        end else begin
            div_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 32'd1;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= ex.op_i;
                        neg_quot_q <= sign_a ^ sign_b;
                        neg_rem_q  <= sign_a;
                        cnt_q      <= 32'd1;
                        if (fast_path) begin
                            rsp_data_q  <= fast_data;
                            rsp_valid_q <= 1'b1;
                            last_q      <= 32'd1;
                            state_q     <= S_RESP;
                        end else begin
                            div_a_q     <= mag_a;
                            div_b_q     <= mag_b;
                            div_valid_q <= 1'b1;
                            state_q     <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    state_q <= ex.flush_i ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    // A done coinciding with the flush has already retired the core op.
                    if (ex.flush_i) begin
                        state_q <= div_done_i ? S_IDLE : S_DRAIN;
                    end else if (div_done_i) begin
                        quot_q  <= div_quot_i;
                        rem_q   <= div_rem_i;
                        state_q <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (ex.flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        rsp_data_q  <= op_is_rem(op_q) ? fix_rem : fix_quot;
                        rsp_valid_q <= 1'b1;
                        last_q      <= cnt_q + 32'd1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (ex.flush_i || ex.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (div_done_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign div_valid_o    = div_valid_q && !ex.flush_i;
    assign div_a_o        = div_a_q;
    assign div_b_o        = div_b_q;
    assign ex.rsp_valid_o = rsp_valid_q;
    assign ex.rsp_data_o  = rsp_data_q;
    assign last_cycles_o  = last_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: vector table, directed flush/stall/reset sequences, random ops.
// A behavioural divider core responds to div_valid_o after core_lat cycles.
module tb_div_issue_ctrl;
    import riscx_div_pkg::*;

    logic        clock;
    logic        nreset;
    logic        div_valid_o;
    logic [31:0] div_a_o;
    logic [31:0] div_b_o;
    logic        div_done_i;
    logic [31:0] div_quot_i;
    logic [31:0] div_rem_i;
    logic [31:0] last_cycles_o;

    int checks   = 0;
    int failures = 0;
    int core_lat = 1;

    div_issue_ctrl_if bus();

    div_issue_ctrl dut (
        .clock         (clock),
        .nreset        (nreset),
        .ex            (bus.slave),
        .div_valid_o   (div_valid_o),
        .div_a_o       (div_a_o),
        .div_b_o       (div_b_o),
        .div_done_i    (div_done_i),
        .div_quot_i    (div_quot_i),
        .div_rem_i     (div_rem_i),
        .last_cycles_o (last_cycles_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    // Divider core: start sampled mid-cycle, done pulse core_lat cycles later.
    initial begin
        logic        busy;
        int          cnt;
        logic [31:0] ca, cb;
        busy = 1'b0; cnt = 0; ca = '0; cb = '0;
        div_done_i = 1'b0; div_quot_i = '0; div_rem_i = '0;
        forever begin
            @(negedge clock);
            div_done_i = 1'b0;
            if (!nreset) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        div_done_i = 1'b1;
                        div_quot_i = (cb == 0) ? '1 : ca / cb;
                        div_rem_i  = (cb == 0) ? ca : ca % cb;
                        busy = 1'b0;
                    end
                end
                if (div_valid_o) begin
                    busy = 1'b1;
                    cnt  = core_lat;
                    ca   = div_a_o;
                    cb   = div_b_o;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic is_sgn, is_rem;
        sa = a; sb = b;
        is_sgn = (op == 2'd0) || (op == 2'd2);
        is_rem = (op == 2'd2) || (op == 2'd3);
        if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
            return is_rem ? sa % sb : sa / sb;
        end
        return is_rem ? a % b : a / b;
    endfunction

    function automatic bit ref_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || ((op == 2'd0 || op == 2'd2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_mag(input logic [1:0] op, input logic [31:0] x);
        return ((op == 2'd0 || op == 2'd2) && x[31]) ? -x : x;
    endfunction

    task automatic step();
        @(posedge clock); #1;
        bus.req_valid_i = 1'b0;
        bus.flush_i     = 1'b0;
    endtask

    // Issues one request, follows it to the response handshake; hold = cycles rsp_ready_i stays low.
    task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input logic [31:0] exp_d, input bit fast, input int hold);
        int n, launches, exp_cyc;
        bit got;
        exp_cyc = fast ? 1 : lat + 3;
        step();
        core_lat        = lat;
        bus.req_valid_i = 1'b1;
        bus.op_i        = div_op_e'(op);
        bus.rs1_i       = a;
        bus.rs2_i       = b;
        bus.rsp_ready_i = (hold == 0);
        @(negedge clock);
        chk("accept_ready", 32'(bus.req_ready_o), 1);
        n = 0; launches = 0; got = 1'b0;
        while (!got && n < 100) begin
            step();
            n++;
            @(negedge clock);
            if (div_valid_o) begin
                launches++;
                chk("div_a", div_a_o, ref_mag(op, a));
                chk("div_b", div_b_o, ref_mag(op, b));
            end
            if (bus.rsp_valid_o) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: no rsp_valid_o within %0d cycles, required %0d", n, exp_cyc);
            return;
        end
        chk("latency", 32'(n), 32'(exp_cyc));
        chk("rsp_data", bus.rsp_data_o, exp_d);
        chk("last_cycles", last_cycles_o, 32'(exp_cyc));
        chk("launches", 32'(launches), fast ? 0 : 1);
        for (int h = 1; h < hold; h++) begin
            step();
            @(negedge clock);
            chk("stall_valid", 32'(bus.rsp_valid_o), 1);
            chk("stall_data", bus.rsp_data_o, exp_d);
        end
        if (hold > 0) begin
            step();
            bus.rsp_ready_i = 1'b1;
            @(negedge clock);
            chk("hs_valid", 32'(bus.rsp_valid_o), 1);
            chk("hs_data", bus.rsp_data_o, exp_d);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] exp_d;
        bit          fast;
    } vec_t;

    initial begin
        vec_t        tbl[$];
        logic [31:0] saved;
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        int          rlat;

        tbl.push_back('{2'd0, 32'hFFFF_FFF9, 32'd2,         3, 32'hFFFF_FFFD, 1'b0});
        tbl.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2,         3, 32'hFFFF_FFFF, 1'b0});
        tbl.push_back('{2'd1, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 1'b1});
        tbl.push_back('{2'd3, 32'd5,         32'd0,         1, 32'd5,         1'b1});
        tbl.push_back('{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b1});
        tbl.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         1'b1});
        tbl.push_back('{2'd1, 32'd100,       32'd7,         4, 32'd14,        1'b0});
        tbl.push_back('{2'd3, 32'd100,       32'd7,         1, 32'd2,         1'b0});
        tbl.push_back('{2'd0, 32'h8000_0000, 32'd1,         2, 32'h8000_0000, 1'b0});
        tbl.push_back('{2'd2, 32'd7,         32'hFFFF_FFFE, 2, 32'd1,         1'b0});
        tbl.push_back('{2'd0, 32'd7,         32'hFFFF_FFFE, 5, 32'hFFFF_FFFD, 1'b0});
        tbl.push_back('{2'd0, 32'd0,         32'd0,         1, 32'hFFFF_FFFF, 1'b1});
        tbl.push_back('{2'd2, 32'h8000_0000, 32'd0,         1, 32'h8000_0000, 1'b1});
        tbl.push_back('{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'd0,         1'b0});
        tbl.push_back('{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h8000_0000, 1'b0});

        nreset = 1'b0;
        bus.req_valid_i = 1'b0; bus.op_i = OP_DIV; bus.rs1_i = '0; bus.rs2_i = '0;
        bus.flush_i = 1'b0; bus.rsp_ready_i = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", 32'(bus.req_ready_o), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("rst_rsp_data", bus.rsp_data_o, 0);
        chk("rst_div_valid", 32'(div_valid_o), 0);
        chk("rst_div_a", div_a_o, 0);
        chk("rst_div_b", div_b_o, 0);
        chk("rst_last_cycles", last_cycles_o, 0);
        @(posedge clock); #1;
        nreset = 1'b1;

        foreach (tbl[i]) run_req(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].exp_d, tbl[i].fast, 0);

        // Response stalled for three cycles, then consumed.
        run_req(2'd1, 32'd9, 32'd2, 1, 32'd4, 1'b0, 3);
        step();
        bus.rsp_ready_i = 1'b0;
        @(negedge clock);
        chk("post_hs_valid", 32'(bus.rsp_valid_o), 0);
        chk("post_hs_ready", 32'(bus.req_ready_o), 1);
        chk("post_hs_data_hold", bus.rsp_data_o, 32'd4);

        // Flush in WAIT: drain until the core's done at cycle 6, accept at cycle 7.
        saved = last_cycles_o;
        step();
        core_lat = 5; bus.rsp_ready_i = 1'b1;
        bus.req_valid_i = 1'b1; bus.op_i = OP_DIVU; bus.rs1_i = 32'd50; bus.rs2_i = 32'd5;
        @(negedge clock);
        step();
        @(negedge clock);
        chk("fw_launch", 32'(div_valid_o), 1);
        step();
        bus.flush_i = 1'b1;
        @(negedge clock);
        for (int c = 3; c <= 6; c++) begin
            step();
            @(negedge clock);
            chk("fw_drain_ready", 32'(bus.req_ready_o), 0);
            chk("fw_drain_rsp", 32'(bus.rsp_valid_o), 0);
        end
        chk("fw_last_cycles", last_cycles_o, saved);
        run_req(2'd3, 32'd50, 32'd7, 2, 32'd1, 1'b0, 0);

        // Flush in LAUNCH suppresses the start pulse.
        step();
        core_lat = 2;
        bus.req_valid_i = 1'b1; bus.op_i = OP_DIV; bus.rs1_i = 32'd100; bus.rs2_i = 32'd3;
        @(negedge clock);
        step();
        bus.flush_i = 1'b1;
        @(negedge clock);
        chk("fl_div_valid", 32'(div_valid_o), 0);
        chk("fl_req_ready", 32'(bus.req_ready_o), 0);
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clock);
            chk("fl_idle_ready", 32'(bus.req_ready_o), 1);
            chk("fl_no_rsp", 32'(bus.rsp_valid_o), 0);
        end

        // Flush in FIXUP (cycle 3): no response, last_cycles_o untouched.
        saved = last_cycles_o;
        step();
        core_lat = 1; bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b1; bus.op_i = OP_DIVU; bus.rs1_i = 32'd20; bus.rs2_i = 32'd3;
        @(negedge clock);
        step(); step();
        step();
        bus.flush_i = 1'b1;
        @(negedge clock);
        step();
        @(negedge clock);
        chk("ff_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("ff_req_ready", 32'(bus.req_ready_o), 1);
        chk("ff_last_cycles", last_cycles_o, saved);

        // Flush in RESP (cycle 4): rsp_valid_o drops the next cycle.
        step();
        bus.req_valid_i = 1'b1; bus.op_i = OP_DIVU; bus.rs1_i = 32'd20; bus.rs2_i = 32'd3;
        @(negedge clock);
        step(); step(); step();
        step();
        bus.flush_i = 1'b1;
        @(negedge clock);
        chk("fr_rsp_valid", 32'(bus.rsp_valid_o), 1);
        chk("fr_rsp_data", bus.rsp_data_o, 32'd6);
        step();
        @(negedge clock);
        chk("fr_rsp_drop", 32'(bus.rsp_valid_o), 0);
        chk("fr_req_ready", 32'(bus.req_ready_o), 1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] v[2];
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 5))
                    0: v[k] = 32'd0;
                    1: v[k] = 32'h8000_0000;
                    2: v[k] = 32'hFFFF_FFFF;
                    3: v[k] = 32'($urandom_range(1, 20));
                    default: v[k] = $urandom;
                endcase
            end
            ra = v[0]; rb = v[1];
            rop  = 2'($urandom_range(0, 3));
            rlat = $urandom_range(1, 6);
            run_req(rop, ra, rb, rlat, ref_result(rop, ra, rb), ref_fast(rop, ra, rb),
                    $urandom_range(0, 2));
        end

        // Asynchronous reset while the core is busy.
        step();
        core_lat = 6; bus.rsp_ready_i = 1'b1;
        bus.req_valid_i = 1'b1; bus.op_i = OP_DIVU; bus.rs1_i = 32'd1000; bus.rs2_i = 32'd10;
        @(negedge clock);
        step(); step();
        @(posedge clock); #1;
        nreset = 1'b0;
        #1;
        chk("ar_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("ar_req_ready", 32'(bus.req_ready_o), 1);
        chk("ar_div_a", div_a_o, 0);
        chk("ar_last_cycles", last_cycles_o, 0);
        chk("ar_rsp_data", bus.rsp_data_o, 0);
        @(negedge clock);
        @(posedge clock); #1;
        nreset = 1'b1;
        run_req(2'd0, 32'hFFFF_FFF9, 32'd2, 3, 32'hFFFF_FFFD, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Initiator-side controller for the iterative unsigned divider core. It sits between the EX stage and the divider and accepts RISC-V M-extension DIV/DIVU/REM/REMU requests. It converts signed operands to magnitudes, drives the core's valid/done handshake, restores result signs and short-circuits the RISC-V special cases (divide-by-zero, signed overflow) without launching the core. It returns one result per request through a valid/ready response port, supports pipeline flush, and reports the cycle count of the last completed operation.

## Interface
- XLEN, 32, operand/result width
- clock  in  1  clock
- nreset  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  controller can accept a request
- op_i  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- rs1_i  in  XLEN  dividend
- rs2_i  in  XLEN  divisor
- flush_i  in  1  kill the in-flight request
- rsp_valid_o  out  1  result available
- rsp_ready_i  in  1  consumer takes result
- rsp_data_o  out  XLEN  result
- div_valid_o  out  1  one-cycle start pulse to the core
- div_a_o  out  XLEN  unsigned dividend magnitude
- div_b_o  out  XLEN  unsigned divisor magnitude (never 0)
- div_done_i  in  1  one-cycle completion pulse from the core
- div_quot_i  in  XLEN  unsigned quotient, valid with div_done_i
- div_rem_i  in  XLEN  unsigned remainder, valid with div_done_i
- last_cycles_o  out  32  accept-to-rsp_valid cycles of the last completed op

## Operation
- States: IDLE, LAUNCH, WAIT, FIXUP, RESP, DRAIN.
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, div_valid_o=0, div_a_o=0, div_b_o=0, last_cycles_o=0.
- req_ready_o = (state==IDLE) && !flush_i.
- A request is accepted on req_valid_i && req_ready_o. On accept, op, operand signs and magnitudes are registered.
  - Magnitudes are abs() for DIV/REM and raw operands for DIVU/REMU.
  - abs(0x80000000) = 0x80000000.
- Fast paths from IDLE go directly to RESP with the result registered:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- Normal path: IDLE→LAUNCH. In LAUNCH, div_valid_o=1 for exactly one cycle → WAIT.
- In WAIT, on div_done_i, div_quot_i and div_rem_i are captured → FIXUP.
- FIXUP (signed ops only; unsigned ops pass through) → RESP:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- In RESP, rsp_valid_o=1 with rsp_data_o stable. When rsp_ready_i=1 → IDLE. rsp_data_o holds its value after the handshake.
- Cycle counter: counts from accept and is written to last_cycles_o on entry to RESP.
- div_done_i outside WAIT and DRAIN is ignored.
- Flush (flush_i has priority over every other event in the same cycle):
  - IDLE: no accept.
  - LAUNCH: div_valid_o is suppressed → IDLE.
  - WAIT: → DRAIN. DRAIN stays until div_done_i, discards the result, then → IDLE.
  - FIXUP or RESP: → IDLE, rsp_valid_o deasserts the next cycle, and last_cycles_o is not updated.
- Reset mid-operation: all state returns to reset values immediately. The core is reset by the same nreset.

## Timing
- Fast path: accept at cycle 0, rsp_valid_o at cycle 1.
- Normal path: accept at cycle 0, div_valid_o at cycle 1, WAIT from cycle 2. If div_done_i arrives at cycle k, rsp_valid_o is asserted at k+2.
- Back-to-back: IDLE is re-entered the cycle after the response handshake, so the next accept is possible one cycle after rsp_valid_o && rsp_ready_i.
- div_a_o and div_b_o are stable from LAUNCH until div_done_i.

## Structure
- Shared package riscx_div_pkg contains:
  - div_op_e (DIV, DIVU, REM, REMU)
  - div_ctrl_state_e
  - constants DIV_ZERO_QUOT='1 and XLEN_INT_MIN=1<<(XLEN-1)
- Sub-module div_sign_fix is combinational and provides abs() on the operand side and conditional negate on the result side. It is instantiated twice: operand magnitudes and result fixup.
- The divider core is not instantiated inside this block; it is connected at the parent level.

## Test plan
- DIV rs1=-7 (0xFFFFFFF9), rs2=2; core returns q=3, r=1 → rsp_data_o=0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- DIVU rs2=0, rs1=5 → rsp_valid_o 1 cycle after accept, data 0xFFFFFFFF, div_valid_o never asserted. REMU with the same operands → 5.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 via the fast path. REM with the same operands → 0.
- Flush in WAIT → DRAIN; core done arrives 4 cycles later with no rsp_valid_o; the next request is accepted the cycle after done and completes correctly.
- rsp_ready_i held low for 3 cycles in RESP → rsp_valid_o and rsp_data_o stable; handshake on cycle 4; req_ready_o high the next cycle.
- DIVU 100/7 with core done at cycle 5 → rsp_valid_o at cycle 7, data 14, last_cycles_o=7.
